grf_wr_arbiter: RTL
===================

Name: grf_wr_arbiter

Overview:
Arbitrates the single GRF write port between two writers:
- the pipeline W-stage writeback, which has priority and zero latency;
- a long-latency unit (multiply/divide result path) using a valid/ready handshake.

The long-latency result is held in a one-entry holding register until the port is free. A wait counter stalls the pipeline for one cycle when that result starves. Outputs drive the GRF RFen/A3/WD/PC8 inputs directly.

Parameters:
MAX_WAIT, 4, consecutive cycles a held LU write may be blocked before a forced grant (1..15)
CNT_W, 4, width of the wait counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
wb_en  input  1  W-stage write request
wb_addr  input  5  W-stage destination register
wb_data  input  32  W-stage write data
wb_pc8  input  32  W-stage PC+8 (trace)
lu_valid  input  1  LU result valid
lu_ready  output  1  arbiter can accept LU result
lu_addr  input  5  LU destination register
lu_data  input  32  LU result
lu_pc8  input  32  LU instruction PC+8
rf_en  output  1  to GRF RFen
rf_a3  output  5  to GRF A3
rf_wd  output  32  to GRF WD
rf_pc8  output  32  to GRF PC8
wb_stall  output  1  freeze pipeline (M/W registers hold) this cycle

Behaviour:
- Single clock clk; reset is synchronous, active-high, and sampled on posedge clk.
- Reset clears: hold_valid=0, hold_addr/data/pc8=0, wait_cnt=0, state=IDLE.
  - Outputs after reset: rf_en=0, rf_a3=0, rf_wd=0, rf_pc8=0, wb_stall=0, lu_ready=1.
  - Reset mid-operation discards any held LU write.
- lu_ready = !hold_valid, combinational. A transfer occurs when lu_valid && lu_ready at posedge; the entry is captured into hold.
- A write with addr 0 from either source is consumed without asserting rf_en.
  - WB addr 0: treated as wb_en=0 for arbitration.
  - LU addr 0: accepted, then never loaded into hold (hold_valid stays 0).
- States:
  - IDLE: hold_valid=0.
  - HELD: hold_valid=1, wait_cnt<MAX_WAIT.
  - FORCE: hold_valid=1, wait_cnt==MAX_WAIT.
- Port mux (combinational):
  - wb_stall=0 and wb_en: port = WB fields; rf_en=1.
  - else if hold_valid: port = hold fields; rf_en=1; hold drains at posedge (hold_valid<=0, wait_cnt<=0). A new LU entry cannot be accepted in the same cycle because lu_ready=0.
  - else: rf_en=0; rf_a3/wd/pc8 = 0.
- HELD: each cycle WB takes the port, wait_cnt increments; on reaching MAX_WAIT, go to FORCE.
- FORCE:
  - wb_stall=1 (combinational from state).
  - Hold is granted the port; the WB write is suppressed and is re-presented next cycle by the stalled pipeline.
  - Next state IDLE, wait_cnt=0.
  - FORCE lasts exactly one cycle.
- Same-address conflict: if wb_en && wb_addr==hold_addr!=0 in a non-FORCE cycle:
  - WB writes;
  - the hold entry is dropped (hold_valid<=0, wait_cnt<=0), because WB holds the newer architectural value.
- Latency:
  - WB to GRF: 0 cycles (same cycle).
  - LU to GRF: minimum 1 cycle after acceptance; maximum MAX_WAIT+1 cycles.
- Simultaneous LU acceptance with reset: reset wins and nothing is captured.

Optional Feature:
GRF_ARB_PERF_EN:
- Defined: adds output ports force_cnt[15:0] and drop_cnt[15:0].
  - force_cnt counts FORCE cycles.
  - drop_cnt counts same-address drops.
  - Both are saturating at 16'hFFFF and cleared by reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - state encodings ARB_IDLE=2'd0, ARB_HELD=2'd1, ARB_FORCE=2'd2;
  - REG_ZERO=5'd0.
- One sub-module: grf_hold_reg (one-entry valid/addr/data/pc8 register with load/clear).
- Arbitration FSM and mux live in the top module.

Test Plan:
1. Reset held 2 cycles, then released → rf_en=0, lu_ready=1, wb_stall=0; a prior hold entry (addr 5) is never written.
2. wb_en=1, addr 3, data 32'h1234 with idle LU → same cycle rf_en=1, rf_a3=3, rf_wd=32'h1234, rf_pc8=wb_pc8.
3. LU accepted (addr 7, data 32'hBEEF) with wb_en=0 → next cycle rf_a3=7, rf_wd=32'hBEEF; lu_ready back to 1 the cycle after.
4. LU accepted (addr 9) while wb_en=1 to addr 4 on every cycle, MAX_WAIT=4 → WB writes for 4 cycles, then wb_stall=1 with rf_a3=9 for exactly one cycle; the WB addr 4 write repeats next cycle.
5. Hold addr 6 while wb_en writes addr 6 → WB value written; hold dropped; rf_a3=6 never carries the LU data; drop_cnt=1 with GRF_ARB_PERF_EN.
6. LU addr 0 accepted, and WB addr 0 → rf_en stays 0; lu_ready stays 1.

Source files
------------

// File: rtl/grf_wr_arbiter_pkg.sv
// Shared types and encodings for the GRF write-port arbiter.
package grf_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_HELD  = 2'd1,
    ARB_FORCE = 2'd2
  } arb_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc8;
  } grf_wr_t;

endpackage

// File: rtl/grf_hold_reg.sv
// One-entry holding register for a pending long-latency GRF write.
module grf_hold_reg
  import grf_wr_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    i_load,
  input  logic    i_clear,
  input  grf_wr_t i_entry,
  output logic    o_valid,
  output grf_wr_t o_entry
);

  logic    r_valid;
  grf_wr_t r_entry;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_entry <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_entry <= i_entry;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_entry = r_entry;

endmodule

// File: rtl/grf_wr_arbiter.sv
// GRF write-port arbiter: W-stage writeback has priority; a held LU result is
// forced through after MAX_WAIT blocked cycles. Optional counters: GRF_ARB_PERF_EN.
module grf_wr_arbiter
  import grf_wr_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc8,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_addr,
  input  logic [31:0] lu_data,
  input  logic [31:0] lu_pc8,
  output logic        rf_en,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd,
  output logic [31:0] rf_pc8,
  output logic        wb_stall
`ifdef GRF_ARB_PERF_EN
  ,
  output logic [15:0] force_cnt,
  output logic [15:0] drop_cnt
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  arb_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt, w_cnt_nxt, w_cnt_inc;

  logic    w_hold_valid;
  grf_wr_t w_hold, w_lu_entry;
  logic    w_force, w_wb_req, w_wb_grant, w_hold_grant, w_conflict, w_accept;

  assign w_lu_entry   = '{addr: lu_addr, data: lu_data, pc8: lu_pc8};
  assign w_force      = (r_state == ARB_FORCE);
  assign w_wb_req     = wb_en && (wb_addr != REG_ZERO);
  assign w_wb_grant   = w_wb_req && !w_force;
  assign w_hold_grant = w_hold_valid && !w_wb_grant;
  // WB carries the newer value for the same register, so the held one is stale.
  assign w_conflict   = w_wb_grant && w_hold_valid && (wb_addr == w_hold.addr);
  assign w_accept     = lu_valid && !w_hold_valid && (lu_addr != REG_ZERO);
  assign w_cnt_inc    = r_wait_cnt + CNT_W'(1);

  assign lu_ready = !w_hold_valid;
  assign wb_stall = w_force;

  grf_hold_reg u_hold (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_accept),
    .i_clear (w_hold_grant || w_conflict),
    .i_entry (w_lu_entry),
    .o_valid (w_hold_valid),
    .o_entry (w_hold)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ARB_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_cnt_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_wait_cnt;
    case (r_state)
      ARB_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ARB_HELD;
          w_cnt_nxt   = '0;
        end
      end
      ARB_HELD: begin
        if (w_hold_grant || w_conflict) begin
          w_state_nxt = ARB_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == MAX_CNT) w_state_nxt = ARB_FORCE;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    rf_en  = 1'b0;
    rf_a3  = REG_ZERO;
    rf_wd  = '0;
    rf_pc8 = '0;
    if (w_wb_grant) begin
      rf_en  = 1'b1;
      rf_a3  = wb_addr;
      rf_wd  = wb_data;
      rf_pc8 = wb_pc8;
    end else if (w_hold_valid) begin
      rf_en  = 1'b1;
      rf_a3  = w_hold.addr;
      rf_wd  = w_hold.data;
      rf_pc8 = w_hold.pc8;
    end
  end

`ifdef GRF_ARB_PERF_EN
  logic [15:0] r_force_cnt, r_drop_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_force_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_force && (r_force_cnt != 16'hFFFF))   r_force_cnt <= r_force_cnt + 16'd1;
      if (w_conflict && (r_drop_cnt != 16'hFFFF)) r_drop_cnt  <= r_drop_cnt + 16'd1;
    end
  end

  assign force_cnt = r_force_cnt;
  assign drop_cnt  = r_drop_cnt;
`endif

endmodule
